// File: rtl/utils.sv
// Shared ghost types and scheduler constants.
package utils;

    typedef enum logic [1:0] {
        SCATTER = 2'd0,
        CHASE   = 2'd1,
        AFFRAID = 2'd2,
        EATEN   = 2'd3
    } ghost_modes_t;

    localparam int         SCHED_CNT_W = 12;
    localparam logic [2:0] LAST_PHASE  = 3'd7;

    localparam int DEF_SCATTER_TICKS       = 420;
    localparam int DEF_SCATTER_SHORT_TICKS = 300;
    localparam int DEF_CHASE_TICKS         = 1200;
    localparam int DEF_AFFRAID_TICKS       = 360;
    localparam int DEF_TWINKLE_TICKS       = 120;
    localparam int DEF_TWINKLE_HALF        = 8;

    // Even phases scatter, odd phases chase.
    function automatic ghost_modes_t phase_mode(input logic [2:0] phase);
        return phase[0] ? CHASE : SCATTER;
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down counter advanced by a tick enable; stops at zero.
module tick_down_counter
    import utils::*;
#(
    parameter int W = SCHED_CNT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick_en,
    output logic [W-1:0] cnt,
    output logic         zero_next
);

    logic [W-1:0] cnt_q;

    // Clear beats load, load beats a decrement.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt       = cnt_q;
    // Flags the tick that takes the count from 1 to 0.
    assign zero_next = tick_en && !load && (cnt_q == W'(1));

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode scheduler: timed scatter/chase phases with an
// AFFRAID override after each big gum, plus the end-of-AFFRAID blink.
module ghost_mode_scheduler
    import utils::*;
#(
    parameter int SCATTER_TICKS       = DEF_SCATTER_TICKS,
    parameter int SCATTER_SHORT_TICKS = DEF_SCATTER_SHORT_TICKS,
    parameter int CHASE_TICKS         = DEF_CHASE_TICKS,
    parameter int AFFRAID_TICKS       = DEF_AFFRAID_TICKS,
    parameter int TWINKLE_TICKS       = DEF_TWINKLE_TICKS,
    parameter int TWINKLE_HALF        = DEF_TWINKLE_HALF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         restart_ghosts,
    input  logic         tick,
    input  logic         pause,
    input  logic         big_gum_eat,
    output ghost_modes_t general_state,
    output ghost_modes_t old_general_state,
    output logic         twinkle,
    output logic         mode_change
);

    localparam logic [SCHED_CNT_W-1:0] SCAT_M1  = SCHED_CNT_W'(SCATTER_TICKS - 1);
    localparam logic [SCHED_CNT_W-1:0] SHORT_M1 = SCHED_CNT_W'(SCATTER_SHORT_TICKS - 1);
    localparam logic [SCHED_CNT_W-1:0] CHASE_M1 = SCHED_CNT_W'(CHASE_TICKS - 1);
    localparam logic [SCHED_CNT_W-1:0] AFF_LOAD = SCHED_CNT_W'(AFFRAID_TICKS);
    localparam logic [SCHED_CNT_W-1:0] TW_LIM   = SCHED_CNT_W'(TWINKLE_TICKS);
    localparam logic [SCHED_CNT_W-1:0] TW_P1    = SCHED_CNT_W'(TWINKLE_TICKS + 1);
    localparam logic [SCHED_CNT_W-1:0] HALF_M1  = SCHED_CNT_W'(TWINKLE_HALF - 1);

    ghost_modes_t           gen_q, gen_d;
    ghost_modes_t           old_q, old_d;
    logic [2:0]             phase_q, phase_d;
    logic [SCHED_CNT_W-1:0] sched_cnt_q, sched_cnt_d;
    logic [SCHED_CNT_W-1:0] tw_cnt_q, tw_cnt_d;
    logic                   tw_q, tw_d;
    logic                   mc_q, mc_d;

    logic                   clr;
    logic                   tick_en;
    logic                   in_aff;
    logic                   phase_end;
    logic                   aff_load;
    logic                   aff_zero_next;
    logic [SCHED_CNT_W-1:0] aff_cnt;
    logic [SCHED_CNT_W-1:0] dur_m1;

    assign clr     = reset | restart_ghosts;
    assign tick_en = tick & ~pause;
    assign in_aff  = (gen_q == AFFRAID);

    tick_down_counter #(
        .W(SCHED_CNT_W)
    ) u_aff_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (aff_load),
        .load_val (AFF_LOAD),
        .tick_en  (tick_en & in_aff),
        .cnt      (aff_cnt),
        .zero_next(aff_zero_next)
    );

    // Last count value of the current phase.
    always_comb begin
        dur_m1 = CHASE_M1;
        case (phase_q)
            3'd0, 3'd2: dur_m1 = SCAT_M1;
            3'd4, 3'd6: dur_m1 = SHORT_M1;
            default:    dur_m1 = CHASE_M1;
        endcase
    end

    // Phase schedule; frozen while AFFRAID, open-ended chase in the last phase.
    always_comb begin
        sched_cnt_d = sched_cnt_q;
        phase_d     = phase_q;
        phase_end   = 1'b0;
        if (!in_aff && tick_en) begin
            if (phase_q == LAST_PHASE) begin
                sched_cnt_d = '0;
            end else if (sched_cnt_q == dur_m1) begin
                phase_end   = 1'b1;
                phase_d     = phase_q + 3'd1;
                sched_cnt_d = '0;
            end else begin
                sched_cnt_d = sched_cnt_q + 1'b1;
            end
        end
    end

    // Mode selection, AFFRAID entry/reload/exit and twinkle timing.
    always_comb begin
        gen_d    = gen_q;
        old_d    = old_q;
        tw_d     = tw_q;
        tw_cnt_d = tw_cnt_q;
        mc_d     = 1'b0;
        aff_load = 1'b0;
        if (!in_aff) begin
            if (big_gum_eat) begin
                // A coincident phase end has already advanced phase_d.
                old_d    = phase_mode(phase_d);
                gen_d    = AFFRAID;
                aff_load = 1'b1;
                mc_d     = 1'b1;
                tw_d     = 1'b0;
                tw_cnt_d = '0;
            end else if (phase_end) begin
                gen_d = phase_mode(phase_d);
                mc_d  = 1'b1;
            end
        end else if (big_gum_eat) begin
            aff_load = 1'b1;
            tw_d     = 1'b0;
            tw_cnt_d = '0;
        end else if (aff_zero_next) begin
            gen_d    = old_q;
            mc_d     = 1'b1;
            tw_d     = 1'b0;
            tw_cnt_d = '0;
        end else if (tick_en) begin
            if (aff_cnt == TW_P1) begin
                tw_d     = 1'b1;
                tw_cnt_d = '0;
            end else if (aff_cnt <= TW_LIM) begin
                if (tw_cnt_q == HALF_M1) begin
                    tw_d     = ~tw_q;
                    tw_cnt_d = '0;
                end else begin
                    tw_cnt_d = tw_cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers; reset and restart clear everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            gen_q       <= SCATTER;
            old_q       <= SCATTER;
            phase_q     <= 3'd0;
            sched_cnt_q <= '0;
            tw_cnt_q    <= '0;
            tw_q        <= 1'b0;
            mc_q        <= 1'b0;
        end else begin
            gen_q       <= gen_d;
            old_q       <= old_d;
            phase_q     <= phase_d;
            sched_cnt_q <= sched_cnt_d;
            tw_cnt_q    <= tw_cnt_d;
            tw_q        <= tw_d;
            mc_q        <= mc_d;
        end
    end

    assign general_state     = gen_q;
    assign old_general_state = old_q;
    assign twinkle           = tw_q;
    assign mode_change       = mc_q;

endmodule
